snum_display_ctrl: RTL

- Sequential controller for a 4-position multiplexed seven-segment display.
- Accepts a signed 8-bit magnitude/sign pair over a valid/ready handshake.
- Extracts decimal digits iteratively with a single shared subtract-by-10 datapath, then places the minus glyph and suppresses leading zeros.
- Writes a shadow glyph bank, commits it atomically, and time-multiplexes the committed bank onto shared segment lines. Sits between the calculator result register and the board display pins.

---
 rtl/snum_display_pkg.sv | 9 +
 rtl/snum_display_ctrl_if.sv | 11 +
 rtl/snum_display_ctrl_sseg_glyph_encoder.sv | 24 ++
 rtl/snum_display_ctrl.sv | 95 +++++++++
 4 files changed

// File: rtl/snum_display_pkg.sv
// snum_display_pkg: glyph codes, FSM states and sizes shared by the display controller
package snum_display_pkg;
  localparam int NUM_POS = 4;
  typedef logic [3:0] glyph_t;
  localparam glyph_t GLYPH_MINUS = 4'hA;
  localparam glyph_t GLYPH_BLANK = 4'hF;
  typedef enum logic [2:0] {S_IDLE, S_DIV, S_EMIT, S_SIGN, S_COMMIT} state_e;
  typedef glyph_t [NUM_POS-1:0] bank_t;
endpackage

// File: rtl/snum_display_ctrl_if.sv
// snum_display_ctrl_if: value/sign load handshake and multiplexed display pins
interface snum_display_ctrl_if;
  logic       load;
  logic [7:0] value;
  logic       neg;
  logic       ready;
  logic [3:0] an;
  logic [6:0] segs;
  modport master (output load, value, neg, input ready, an, segs);
  modport slave (input load, value, neg, output ready, an, segs);
endinterface

// File: rtl/snum_display_ctrl_sseg_glyph_encoder.sv
// sseg_glyph_encoder: glyph code to active-low segments a..g, unknown codes blank
module sseg_glyph_encoder
  import snum_display_pkg::*;
(
  input  glyph_t     glyph_i,
  output logic [6:0] segs_o
);
  always_comb begin
    case (glyph_i)
      4'd0:        segs_o = 7'h40;
      4'd1:        segs_o = 7'h79;
      4'd2:        segs_o = 7'h24;
      4'd3:        segs_o = 7'h30;
      4'd4:        segs_o = 7'h19;
      4'd5:        segs_o = 7'h12;
      4'd6:        segs_o = 7'h02;
      4'd7:        segs_o = 7'h78;
      4'd8:        segs_o = 7'h00;
      4'd9:        segs_o = 7'h10;
      GLYPH_MINUS: segs_o = 7'h3F;
      default:     segs_o = 7'h7F;
    endcase
  end
endmodule

// File: rtl/snum_display_ctrl.sv
// snum_display_ctrl: iterative signed-decimal conversion into a shadow bank, atomic commit, 4-digit scan
module snum_display_ctrl
  import snum_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input logic clk,
  input logic reset,
  snum_display_ctrl_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  state_e         state_q;
  logic [7:0]     rem_q, quot_q;
  logic           sign_q, nz_q, ready_q;
  logic [1:0]     idx_q, scan_q;
  bank_t          shadow_q, committed_q, sign_bank_d;
  logic [CW-1:0]  cnt_q;
  logic [3:0]     an_q;
  logic [6:0]     segs_q, segs_d;
  glyph_t         glyph_d;
  // Positions above the last digit get the minus (if any) directly above, blanks beyond
  always_comb begin
    for (int i = 0; i < NUM_POS; i++)
      sign_bank_d[i] = (2'(i) > idx_q) ?
                       ((2'(i) == idx_q + 2'd1 && sign_q && nz_q) ? GLYPH_MINUS : GLYPH_BLANK) :
                       shadow_q[i];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      quot_q      <= '0;
      sign_q      <= 1'b0;
      nz_q        <= 1'b0;
      idx_q       <= '0;
      ready_q     <= 1'b1;
      shadow_q    <= {NUM_POS{GLYPH_BLANK}};
      committed_q <= {NUM_POS{GLYPH_BLANK}};
    end else begin
      case (state_q)
        S_IDLE: if (bus.load && ready_q) begin
          rem_q   <= bus.value;
          quot_q  <= '0;
          sign_q  <= bus.neg;
          nz_q    <= |bus.value;
          idx_q   <= '0;
          ready_q <= 1'b0;
          state_q <= S_DIV;
        end
        S_DIV: if (rem_q >= 8'd10) begin
          rem_q  <= rem_q - 8'd10;
          quot_q <= quot_q + 8'd1;
        end else state_q <= S_EMIT;
        S_EMIT: begin
          shadow_q[idx_q] <= rem_q[3:0];
          if (quot_q == '0) state_q <= S_SIGN;
          else begin
            rem_q   <= quot_q;
            quot_q  <= '0;
            idx_q   <= idx_q + 2'd1;
            state_q <= S_DIV;
          end
        end
        S_SIGN: begin
          shadow_q <= sign_bank_d;
          state_q  <= S_COMMIT;
        end
        S_COMMIT: begin
          committed_q <= shadow_q;
          ready_q     <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign glyph_d = committed_q[scan_q];
  sseg_glyph_encoder u_enc (.glyph_i(glyph_d), .segs_o(segs_d));
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      scan_q <= '0;
      an_q   <= 4'hF;
      segs_q <= 7'h7F;
    end else begin
      cnt_q  <= (cnt_q == CW'(REFRESH_DIV - 1)) ? '0 : cnt_q + 1'b1;
      scan_q <= (cnt_q == CW'(REFRESH_DIV - 1)) ? scan_q + 2'd1 : scan_q;
      an_q   <= (glyph_d == GLYPH_BLANK) ? 4'hF : ~(4'b0001 << scan_q);
      segs_q <= segs_d;
    end
  end
  assign bus.ready = ready_q;
  assign bus.an    = an_q;
  assign bus.segs  = segs_q;
endmodule
